// File: rtl/mem_bus_buffer.sv
// FIFO-backed memory data bus driver: queues ALU words and drives them when the bus is free.
// Define MBUF_BUS_HOLD_EN to keep the last popped word on mdat_out while the bus is not driven.
module mem_bus_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mrd,
    input  logic                       fetch,
    input  logic                       clk2,
    input  logic                       wr_valid,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_ready,
    output logic [WIDTH-1:0]           mdat_out,
    output logic                       mdat_oe,
    input  logic [WIDTH-1:0]           mdat_in,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_wr_ready;
    logic [WIDTH-1:0] r_mdat_out;
    logic             r_mdat_oe;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;

    logic             w_win;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    assign w_win  = ~(mrd | fetch | clk2);
    // Status comes from the registered count, so a pop while full cannot make room this cycle.
    assign w_push = wr_valid & ~r_full;
    assign w_pop  = w_win & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_wr_ready <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CW'(DEPTH));
            r_empty    <= (w_count_nxt == '0);
            r_wr_ready <= (w_count_nxt != CW'(DEPTH));
            if (wr_valid && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdat_out <= '0;
            r_mdat_oe  <= 1'b0;
        end else begin
            r_mdat_oe <= w_pop;
            if (w_pop) begin
                r_mdat_out <= r_mem[r_rptr];
            end else begin
`ifdef MBUF_BUS_HOLD_EN
                r_mdat_out <= r_mdat_out;
`else
                r_mdat_out <= '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= mrd;
            if (mrd) begin
                r_rd_data <= mdat_in;
            end
        end
    end

    assign wr_ready = r_wr_ready;
    assign mdat_out = r_mdat_out;
    assign mdat_oe  = r_mdat_oe;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign full     = r_full;
    assign empty    = r_empty;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_mem_bus_buffer.sv
// Directed bench for mem_bus_buffer (WIDTH=8, DEPTH=4); expectations track MBUF_BUS_HOLD_EN.
module tb_mem_bus_buffer;

    logic       clk;
    logic       rst_n;
    logic       mrd;
    logic       fetch;
    logic       clk2;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [7:0] mdat_out;
    logic       mdat_oe;
    logic [7:0] mdat_in;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_buffer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mrd      (mrd),
        .fetch    (fetch),
        .clk2     (clk2),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .mdat_out (mdat_out),
        .mdat_oe  (mdat_oe),
        .mdat_in  (mdat_in),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MBUF_BUS_HOLD_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic oe, input logic [7:0] dat);
        check_val({tag, "_oe"}, 32'(mdat_oe), 32'(oe));
        check_val({tag, "_dat"}, 32'(mdat_out), 32'(dat));
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_dat"}, 32'(mdat_out), 32'h0);
        check_val({tag, "_oe"}, 32'(mdat_oe), 32'h0);
        check_val({tag, "_rdd"}, 32'(rd_data), 32'h0);
        check_val({tag, "_rdv"}, 32'(rd_valid), 32'h0);
        check_val({tag, "_cnt"}, 32'(count), 32'h0);
        check_val({tag, "_empty"}, 32'(empty), 32'h1);
        check_val({tag, "_full"}, 32'(full), 32'h0);
        check_val({tag, "_rdy"}, 32'(wr_ready), 32'h1);
        check_val({tag, "_ovf"}, 32'(overflow), 32'h0);
    endtask

    initial begin
        logic [7:0] seq3 [3];
        logic [7:0] seqa [4];
        logic [7:0] idle_dat;

        seq3 = '{8'h11, 8'h22, 8'h33};
        seqa = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

        rst_n = 1'b0; mrd = 1'b0; fetch = 1'b0; clk2 = 1'b0;
        wr_valid = 1'b0; wr_data = 8'h00; mdat_in = 8'h00;
        #12;
        check_reset_state("rst");
        #3 rst_n = 1'b1;
        tick();

        // Streaming: push 11,22,33 with window open
        wr_valid = 1'b1; wr_data = seq3[0];
        tick();
        check_val("s_cnt0", 32'(count), 32'h1);
        check_val("s_oe0", 32'(mdat_oe), 32'h0);
        for (int i = 1; i < 3; i++) begin
            wr_data = seq3[i];
            tick();
            check_bus("s_pop", 1'b1, seq3[i-1]);
            check_val("s_cnt", 32'(count), 32'h1);
        end
        wr_valid = 1'b0;
        tick();
        check_bus("s_last", 1'b1, seq3[2]);
        check_val("s_cnt_end", 32'(count), 32'h0);
        check_val("s_empty", 32'(empty), 32'h1);
        tick();
        check_bus("s_idle", 1'b0, HOLD ? seq3[2] : 8'h00);

        // Fill while clk2 blocks, then overflow
        clk2 = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = seqa[i];
            tick();
        end
        check_val("f_cnt", 32'(count), 32'h4);
        check_val("f_full", 32'(full), 32'h1);
        check_val("f_rdy", 32'(wr_ready), 32'h0);
        check_val("f_oe", 32'(mdat_oe), 32'h0);
        check_val("f_ovf0", 32'(overflow), 32'h0);
        wr_data = 8'hFF;
        tick();
        check_val("f_ovf1", 32'(overflow), 32'h1);
        check_val("f_cnt_ovf", 32'(count), 32'h4);
        wr_valid = 1'b0; clk2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_bus("f_drain", 1'b1, seqa[i]);
        end
        tick();
        check_bus("f_done", 1'b0, HOLD ? seqa[3] : 8'h00);
        check_val("f_empty", 32'(empty), 32'h1);
        check_val("f_ovf_sticky", 32'(overflow), 32'h1);

        // Simultaneous push and pop at count 2
        clk2 = 1'b1; wr_valid = 1'b1;
        wr_data = 8'h41; tick();
        wr_data = 8'h42; tick();
        check_val("pp_cnt2", 32'(count), 32'h2);
        clk2 = 1'b0; wr_data = 8'h55;
        tick();
        check_bus("pp_first", 1'b1, 8'h41);
        check_val("pp_cnt_same", 32'(count), 32'h2);
        wr_valid = 1'b0;
        tick();
        check_bus("pp_second", 1'b1, 8'h42);
        tick();
        check_bus("pp_third", 1'b1, 8'h55);
        check_val("pp_cnt0", 32'(count), 32'h0);
        tick();
        check_val("pp_oe_off", 32'(mdat_oe), 32'h0);

        // Fetch blocks the bus without capture; mrd captures
        clk2 = 1'b1; wr_valid = 1'b1; wr_data = 8'h77;
        tick();
        wr_valid = 1'b0; clk2 = 1'b0; fetch = 1'b1; mdat_in = 8'hE5;
        tick();
        check_val("fe_oe", 32'(mdat_oe), 32'h0);
        check_val("fe_rdv", 32'(rd_valid), 32'h0);
        check_val("fe_rdd", 32'(rd_data), 32'h0);
        fetch = 1'b0; mrd = 1'b1; mdat_in = 8'h3C;
        tick();
        check_val("rd_data", 32'(rd_data), 32'h3C);
        check_val("rd_valid1", 32'(rd_valid), 32'h1);
        check_val("rd_oe", 32'(mdat_oe), 32'h0);
        check_val("rd_cnt", 32'(count), 32'h1);
        mrd = 1'b0; mdat_in = 8'h00;
        tick();
        check_val("rd_valid0", 32'(rd_valid), 32'h0);
        check_val("rd_hold", 32'(rd_data), 32'h3C);
        check_bus("rd_after", 1'b1, 8'h77);
        tick();
        check_val("rd_oe_off", 32'(mdat_oe), 32'h0);

        // Reset mid-drain
        clk2 = 1'b1; wr_valid = 1'b1;
        wr_data = 8'h61; tick();
        wr_data = 8'h62; tick();
        wr_data = 8'h63; tick();
        check_val("r_cnt3", 32'(count), 32'h3);
        wr_valid = 1'b0; clk2 = 1'b0;
        tick();
        check_bus("r_pop", 1'b1, 8'h61);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("r_async");
        tick();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bus("r_quiet", 1'b0, 8'h00);
            check_val("r_quiet_cnt", 32'(count), 32'h0);
        end

        // Bus keeper behaviour after window closes
        wr_valid = 1'b1; wr_data = 8'h9C;
        tick();
        wr_valid = 1'b0;
        tick();
        check_bus("k_pop", 1'b1, 8'h9C);
        clk2 = 1'b1;
        tick();
        idle_dat = HOLD ? 8'h9C : 8'h00;
        check_bus("k_closed", 1'b0, idle_dat);
        clk2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
